// File: rtl/id_ex_execute_if.sv
// Bundle of the ID/EX boundary and execute-stage signals.
// The master side is the decode/hazard/forwarding logic, the slave side is the EX stage.
interface id_ex_execute_if #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
);
    // hazard control
    logic               stall;
    logic               flush;
    // decoded instruction from ID
    logic               valid_d;
    logic [3:0]         alucontrol_d;
    logic               alusrc_d;
    logic               branch_d;
    logic               jump_d;
    logic               jalr_d;
    logic               regwrite_d;
    logic [2:0]         funct3_d;
    logic [XLEN-1:0]    rd1_d;
    logic [XLEN-1:0]    rd2_d;
    logic [XLEN-1:0]    immext_d;
    logic [XLEN-1:0]    pc_d;
    logic [REGADDR-1:0] rd_d;
    // forwarding
    logic [1:0]         forward_a_e;
    logic [1:0]         forward_b_e;
    logic [XLEN-1:0]    result_w;
    logic [XLEN-1:0]    aluresult_m;
    // execute results
    logic               valid_e;
    logic [XLEN-1:0]    aluresult_e;
    logic               zero_e;
    logic               pcsrc_e;
    logic [XLEN-1:0]    pctarget_e;
    logic [XLEN-1:0]    writedata_e;
    logic [REGADDR-1:0] rd_e;
    logic               regwrite_e;
    logic               illegal_e;

    modport master (
        output stall, flush, valid_d, alucontrol_d, alusrc_d, branch_d, jump_d, jalr_d,
               regwrite_d, funct3_d, rd1_d, rd2_d, immext_d, pc_d, rd_d,
               forward_a_e, forward_b_e, result_w, aluresult_m,
        input  valid_e, aluresult_e, zero_e, pcsrc_e, pctarget_e, writedata_e, rd_e,
               regwrite_e, illegal_e
    );

    modport slave (
        input  stall, flush, valid_d, alucontrol_d, alusrc_d, branch_d, jump_d, jalr_d,
               regwrite_d, funct3_d, rd1_d, rd2_d, immext_d, pc_d, rd_d,
               forward_a_e, forward_b_e, result_w, aluresult_m,
        output valid_e, aluresult_e, zero_e, pcsrc_e, pctarget_e, writedata_e, rd_e,
               regwrite_e, illegal_e
    );
endinterface

// File: rtl/id_ex_execute.sv
// ID/EX pipeline register followed by the execute stage: forwarding muxes,
// ALU and branch/jump resolution. Flush loads a bubble, stall holds the slot.
// No handshake: the slot is qualified by valid_e, and every side effect
// (redirect, register write, illegal flag) is gated by it.
module id_ex_execute #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
) (
    input logic             clk,
    input logic             rst_n,
    id_ex_execute_if.slave  bus
);

    logic               valid_q;
    logic [3:0]         alucontrol_q;
    logic               alusrc_q;
    logic               branch_q;
    logic               jump_q;
    logic               jalr_q;
    logic               regwrite_q;
    logic [2:0]         funct3_q;
    logic [XLEN-1:0]    rd1_q;
    logic [XLEN-1:0]    rd2_q;
    logic [XLEN-1:0]    immext_q;
    logic [XLEN-1:0]    pc_q;
    logic [REGADDR-1:0] rd_q;

    logic [XLEN-1:0]    src_a;
    logic [XLEN-1:0]    fwd_b;
    logic [XLEN-1:0]    src_b;
    logic [XLEN-1:0]    alu_y;
    logic [XLEN-1:0]    target_sum;
    logic [4:0]         shamt;
    logic               alu_zero;
    logic               cond;
    logic               illegal_op;

    // ID/EX register: flush beats stall beats load; flush clears only control bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alucontrol_q <= '0;
            alusrc_q     <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            jalr_q       <= 1'b0;
            regwrite_q   <= 1'b0;
            funct3_q     <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            immext_q     <= '0;
            pc_q         <= '0;
            rd_q         <= '0;
        end else if (bus.flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
        end else if (!bus.stall) begin
            valid_q      <= bus.valid_d;
            alucontrol_q <= bus.alucontrol_d;
            alusrc_q     <= bus.alusrc_d;
            branch_q     <= bus.branch_d;
            jump_q       <= bus.jump_d;
            jalr_q       <= bus.jalr_d;
            regwrite_q   <= bus.regwrite_d;
            funct3_q     <= bus.funct3_d;
            rd1_q        <= bus.rd1_d;
            rd2_q        <= bus.rd2_d;
            immext_q     <= bus.immext_d;
            pc_q         <= bus.pc_d;
            rd_q         <= bus.rd_d;
        end
    end

    // Forwarding muxes; select 11 falls back to the register-file value
    always_comb begin
        src_a = rd1_q;
        fwd_b = rd2_q;
        case (bus.forward_a_e)
            2'b01:   src_a = bus.result_w;
            2'b10:   src_a = bus.aluresult_m;
            default: src_a = rd1_q;
        endcase
        case (bus.forward_b_e)
            2'b01:   fwd_b = bus.result_w;
            2'b10:   fwd_b = bus.aluresult_m;
            default: fwd_b = rd2_q;
        endcase
        src_b = alusrc_q ? immext_q : fwd_b;
    end

    assign shamt = src_b[4:0];

    // ALU; the reserved encodings 1010..1111 produce zero
    always_comb begin
        alu_y      = '0;
        illegal_op = 1'b0;
        case (alucontrol_q)
            4'b0000: alu_y = src_a + src_b;
            4'b0001: alu_y = src_a - src_b;
            4'b0010: alu_y = src_a << shamt;
            4'b0011: alu_y = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0100: alu_y = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b0101: alu_y = src_a ^ src_b;
            4'b0110: alu_y = src_a >> shamt;
            4'b0111: alu_y = $unsigned($signed(src_a) >>> shamt);
            4'b1000: alu_y = src_a | src_b;
            4'b1001: alu_y = src_a & src_b;
            default: begin
                alu_y      = '0;
                illegal_op = 1'b1;
            end
        endcase
    end

    assign alu_zero = (alu_y == '0);

    // Branch condition: blt/bltu rely on the ALU doing slt/sltu, so a nonzero result means taken
    always_comb begin
        cond = 1'b0;
        case (funct3_q)
            3'b000:  cond = alu_zero;
            3'b001:  cond = !alu_zero;
            3'b100:  cond = !alu_zero;
            3'b110:  cond = !alu_zero;
            3'b101:  cond = alu_zero;
            3'b111:  cond = alu_zero;
            default: cond = 1'b0;
        endcase
    end

    assign target_sum = (jalr_q ? src_a : pc_q) + immext_q;

    assign bus.valid_e     = valid_q;
    assign bus.aluresult_e = alu_y;
    assign bus.zero_e      = alu_zero;
    assign bus.pctarget_e  = jalr_q ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
    assign bus.pcsrc_e     = valid_q & (jump_q | (branch_q & cond));
    assign bus.writedata_e = fwd_b;
    assign bus.rd_e        = rd_q;
    assign bus.regwrite_e  = regwrite_q & valid_q;
    assign bus.illegal_e   = valid_q & illegal_op;

endmodule
